// File: rtl/nibble_serial_add_ctrl.sv
// rtl/nibble_serial_add_ctrl.sv - wide add/sub sequenced one nibble per cycle through a shared 4-bit adder slice
module nibble_serial_add_ctrl #(
  parameter int NIBBLES = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [4*NIBBLES-1:0]   a,
  input  logic [4*NIBBLES-1:0]   b,
  input  logic                   cin,
  input  logic                   sub,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [4*NIBBLES-1:0]   sum,
  output logic                   cout,
  output logic                   overflow,
  output logic                   busy,
  output logic [3:0]             adder_a,
  output logic [3:0]             adder_b,
  output logic                   adder_cin,
  input  logic [3:0]             adder_s,
  input  logic                   adder_co
);

  localparam int W  = 4 * NIBBLES;
  localparam int IW = $clog2(NIBBLES);
  localparam logic [IW-1:0] LAST = IW'(NIBBLES - 1);
  localparam logic [IW-1:0] ONE  = IW'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t         state;
  state_t         state_nxt;
  logic [IW-1:0]  idx;
  logic           carry;
  logic [W-1:0]   a_reg;
  logic [W-1:0]   b_reg;
  logic [W-1:0]   sum_r;
  logic           cout_r;
  logic           ovf_r;
  logic [W-1:0]   a_shift;
  logic [W-1:0]   b_shift;
  logic           accept;
  logic           in_run;
  logic           last_pass;

  assign accept    = (state == S_IDLE) && in_valid;
  assign in_run    = (state == S_RUN);
  assign last_pass = in_run && (idx == LAST);

  // Select the current nibble of each operand by shifting it down to bit 0
  assign a_shift = a_reg >> {idx, 2'b00};
  assign b_shift = b_reg >> {idx, 2'b00};

  // State register; reset abandons any in-flight operation
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state: accept in IDLE, leave RUN after the last nibble, leave DONE on consumer take
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (in_valid)  state_nxt = S_RUN;
      S_RUN:   if (last_pass) state_nxt = S_DONE;
      S_DONE:  if (out_ready) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Outputs: handshake flags from state, slice inputs only driven while running
  always_comb begin
    in_ready  = (state == S_IDLE);
    out_valid = (state == S_DONE);
    busy      = (state != S_IDLE);
    adder_a   = 4'd0;
    adder_b   = 4'd0;
    adder_cin = 1'b0;
    if (in_run) begin
      adder_a   = a_shift[3:0];
      adder_b   = b_shift[3:0];
      adder_cin = carry;
    end
  end

  // Datapath: capture operands (B pre-inverted for subtract), then collect one nibble per pass
  always_ff @(posedge clk) begin
    if (rst) begin
      idx    <= '0;
      carry  <= 1'b0;
      a_reg  <= '0;
      b_reg  <= '0;
      sum_r  <= '0;
      cout_r <= 1'b0;
      ovf_r  <= 1'b0;
    end else if (accept) begin
      a_reg <= a;
      b_reg <= sub ? ~b : b;
      carry <= sub | cin;
      idx   <= '0;
    end else if (in_run) begin
      for (int i = 0; i < NIBBLES; i++) begin
        if (int'(idx) == i) begin
          sum_r[4*i +: 4] <= adder_s;
        end
      end
      carry <= adder_co;
      if (idx == LAST) begin
        cout_r <= adder_co;
        ovf_r  <= a_reg[W-1] ^ b_reg[W-1] ^ adder_s[3] ^ adder_co;
      end else begin
        idx <= idx + ONE;
      end
    end
  end

  assign sum      = sum_r;
  assign cout     = cout_r;
  assign overflow = ovf_r;

endmodule

// File: tb/tb_nibble_serial_add_ctrl.sv
// tb/tb_nibble_serial_add_ctrl.sv - directed vector bench for nibble_serial_add_ctrl
module tb_nibble_serial_add_ctrl;

  localparam int N = 4;
  localparam int W = 4 * N;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         sub;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         cout;
  logic         overflow;
  logic         busy;
  logic [3:0]   adder_a;
  logic [3:0]   adder_b;
  logic         adder_cin;
  logic [3:0]   adder_s;
  logic         adder_co;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  // External 4-bit slice model
  assign {adder_co, adder_s} = {1'b0, adder_a} + {1'b0, adder_b} + {4'b0000, adder_cin};

  nibble_serial_add_ctrl #(.NIBBLES(N)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .sub(sub),
    .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .overflow(overflow), .busy(busy),
    .adder_a(adder_a), .adder_b(adder_b), .adder_cin(adder_cin),
    .adder_s(adder_s), .adder_co(adder_co)
  );

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         sub;
    logic [W-1:0] exp_sum;
    logic         exp_cout;
    logic         exp_ovf;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Called at a negedge with the DUT in IDLE; returns at the negedge after out_valid is consumed
  task automatic run_op(input vec_t v, input string tag, output logic [N-1:0] cin_seq);
    int wait_cyc;
    logic early;
    cin_seq = '0;
    early = 1'b0;
    in_valid = 1'b1; a = v.a; b = v.b; cin = v.cin; sub = v.sub; out_ready = 1'b0;
    chk({tag, " in_ready"}, 32'(in_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0; a = '1; b = '1; cin = 1'b1; sub = 1'b1;
    for (int i = 0; i < N; i++) begin
      if (out_valid) early = 1'b1;
      cin_seq[i] = adder_cin;
      @(posedge clk);
      @(negedge clk);
    end
    chk({tag, " early_valid"}, 32'(early), 32'd0);
    wait_cyc = 0;
    while (!out_valid && wait_cyc < 20) begin
      @(posedge clk); @(negedge clk);
      wait_cyc++;
    end
    chk({tag, " latency"}, 32'(wait_cyc), 32'd0);
    chk({tag, " sum"}, 32'(sum), 32'(v.exp_sum));
    chk({tag, " cout"}, 32'(cout), 32'(v.exp_cout));
    chk({tag, " ovf"}, 32'(overflow), 32'(v.exp_ovf));
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    chk({tag, " back_idle"}, {30'd0, out_valid, in_ready}, 32'b01);
  endtask

  initial begin
    logic [N-1:0] cs;
    logic held_ok;
    int edge_no;
    int nacc;
    int acc_edge[2];
    logic [W-1:0] res[$];
    logic [W-1:0] res_c[$];

    vecs[0] = '{16'h1234, 16'h0FFF, 1'b0, 1'b0, 16'h2233, 1'b0, 1'b0};
    vecs[1] = '{16'hFFFF, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0};
    vecs[2] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
    vecs[3] = '{16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0};
    vecs[4] = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1};
    vecs[5] = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1};
    vecs[6] = '{16'h1000, 16'h1000, 1'b1, 1'b1, 16'h0000, 1'b1, 1'b0};
    vecs[7] = '{16'hABCD, 16'h1111, 1'b1, 1'b0, 16'hBCDF, 1'b0, 1'b0};

    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    chk("reset in_ready", 32'(in_ready), 32'd1);
    chk("reset out_valid", 32'(out_valid), 32'd0);
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset sum", 32'(sum), 32'd0);
    chk("reset cout_ovf", {30'd0, cout, overflow}, 32'd0);
    chk("reset adder", {23'd0, adder_a, adder_b, adder_cin}, 32'd0);

    for (int i = 0; i < 8; i++) begin
      run_op(vecs[i], $sformatf("vec%0d", i), cs);
      if (i == 0) chk("vec0 cin_seq", 32'(cs), 32'b1110);
    end

    // Backpressure: result must hold while the consumer stalls and new requests are ignored
    in_valid = 1'b1; a = 16'h1111; b = 16'h2222; cin = 1'b0; sub = 1'b0; out_ready = 1'b0;
    @(posedge clk); @(negedge clk);
    in_valid = 1'b0;
    repeat (N) begin @(posedge clk); @(negedge clk); end
    chk("bp valid_rise", 32'(out_valid), 32'd1);
    held_ok = 1'b1;
    for (int i = 0; i < 6; i++) begin
      in_valid = ~in_valid; a = a + 16'h0101; b = ~b;
      @(posedge clk); @(negedge clk);
      if (sum !== 16'h3333 || in_ready !== 1'b0 || out_valid !== 1'b1 || busy !== 1'b1) held_ok = 1'b0;
    end
    chk("bp held", 32'(held_ok), 32'd1);
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    out_ready = 1'b0;
    chk("bp release", {30'd0, in_ready, out_valid}, 32'b10);

    // Reset during the second RUN cycle
    in_valid = 1'b1; a = 16'h5555; b = 16'h1111; cin = 1'b0; sub = 1'b0;
    @(posedge clk); @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk); @(negedge clk);
    chk("rst midrun busy", 32'(busy), 32'd1);
    rst = 1'b1;
    @(posedge clk); @(negedge clk);
    rst = 1'b0;
    chk("rst midrun state", {29'd0, in_ready, out_valid, busy}, 32'b100);
    chk("rst midrun sum", 32'(sum), 32'd0);
    chk("rst midrun adder", {23'd0, adder_a, adder_b, adder_cin}, 32'd0);
    run_op('{16'h0001, 16'h0001, 1'b0, 1'b0, 16'h0002, 1'b0, 1'b0}, "post_rst", cs);

    // Back-to-back with in_valid held high
    in_valid = 1'b1; a = 16'h00FF; b = 16'h0001; cin = 1'b0; sub = 1'b0; out_ready = 1'b1;
    nacc = 0; edge_no = 0; acc_edge[0] = 0; acc_edge[1] = 0;
    for (int t = 0; t < 40 && res.size() < 2; t++) begin
      if (out_valid) begin
        res.push_back(sum);
        res_c.push_back({15'd0, cout});
      end
      if (in_ready && in_valid && nacc < 2) begin
        acc_edge[nacc] = edge_no;
        nacc++;
      end
      @(posedge clk);
      edge_no++;
      @(negedge clk);
      if (nacc == 1) begin a = 16'h4321; b = 16'h1234; end
      if (nacc == 2) in_valid = 1'b0;
    end
    out_ready = 1'b0;
    chk("b2b accepts", 32'(nacc), 32'd2);
    chk("b2b spacing", 32'(acc_edge[1] - acc_edge[0]), 32'(N + 2));
    chk("b2b results", 32'(res.size()), 32'd2);
    if (res.size() == 2) begin
      chk("b2b sum0", 32'(res[0]), 32'h0100);
      chk("b2b sum1", 32'(res[1]), 32'h5555);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/nibble_serial_add_ctrl.md
Name: nibble_serial_add_ctrl

Overview:
- Sequencer that computes wide add/subtract results by time-multiplexing one external combinational 4-bit parallel adder slice, one nibble per cycle, LSB nibble first.
- The block owns operand/result registers, the ripple carry between passes, and a valid/ready handshake on both sides.
- It sits between a requesting datapath and the shared 4-bit adder; the adder's S/Co outputs feed back into this block.

Parameters:
- NIBBLES, 4, number of 4-bit passes per operation; operand width W = 4*NIBBLES; legal range 2..16.

Ports:
- clk  input  1  sole clock, rising edge.
- rst  input  1  synchronous reset, active-high.
- in_valid  input  1  request present.
- in_ready  output  1  block can accept a request.
- a  input  W  operand A.
- b  input  W  operand B.
- cin  input  1  carry-in for add mode; ignored when sub=1.
- sub  input  1  1 = compute a - b (two's complement).
- out_valid  output  1  result registers valid.
- out_ready  input  1  consumer takes result.
- sum  output  W  result.
- cout  output  1  carry out of the final pass (for sub: 1 = no borrow).
- overflow  output  1  signed overflow of the W-bit result.
- busy  output  1  high in RUN or DONE.
- adder_a  output  4  nibble of A to slice.
- adder_b  output  4  nibble of effective B to slice.
- adder_cin  output  1  carry to slice.
- adder_s  input  4  slice sum (combinational from adder_a/b/cin).
- adder_co  input  1  slice carry out.

Behaviour:
- Reset (synchronous, rst=1 at rising edge): state=IDLE, idx=0, carry=0, a_reg/b_reg/sum=0, cout=0, overflow=0, out_valid=0. Overrides everything, including mid-RUN or DONE; the in-flight operation is discarded with no output.
- States:
  - IDLE: in_ready=1. On in_valid&&in_ready: capture a_reg=a, b_reg = sub ? ~b : b, carry = sub ? 1 : cin; idx=0; go to RUN.
  - RUN: in_ready=0. Drive adder_a=a_reg[4*idx+:4], adder_b=b_reg[4*idx+:4], adder_cin=carry. Each edge: sum[4*idx+:4]=adder_s, carry=adder_co, idx=idx+1. On the edge where idx==NIBBLES-1, also cout=adder_co, overflow = a_reg[W-1] ^ b_reg[W-1] ^ adder_s[3] ^ adder_co, then go to DONE.
  - DONE: out_valid=1; sum/cout/overflow stable. On out_ready=1, go to IDLE and clear out_valid. Hold indefinitely while out_ready=0.
- Outside RUN, adder_a, adder_b and adder_cin are driven 0.
- Latency:
  - Accept at edge k; RUN occupies edges k+1..k+NIBBLES; out_valid is high from edge k+NIBBLES.
  - A new request is accepted no earlier than the edge after the DONE-to-IDLE transition, so peak throughput is one op per NIBBLES+2 cycles.
- in_valid and operand changes during RUN/DONE are ignored; operands are sampled only at acceptance.
- sum nibbles not yet written in RUN keep their previous values. Consumers use sum only when out_valid=1.
- Arithmetic:
  - Result is modulo 2^W.
  - cout is bit W of a + b_eff + carry0.
  - overflow follows the signed rule: carry into MSB xor carry out of MSB.
- idx width is clog2(NIBBLES). idx never wraps past NIBBLES-1; it is reset to 0 on each acceptance.

Test Plan:
- NIBBLES=4, add 0x1234 + 0x0FFF, cin=0 -> after 4 RUN cycles out_valid=1, sum=0x2233, cout=0, overflow=0. Bench models adder_s/co as {co,s}=adder_a+adder_b+adder_cin; adder_cin sequence is 0,1,1,1.
- Add 0xFFFF + 0x0000, cin=1 -> sum=0x0000, cout=1, overflow=0. Add 0x7FFF + 0x0001 -> sum=0x8000, cout=0, overflow=1.
- sub=1: 0x0005 - 0x0007 -> sum=0xFFFE, cout=0, overflow=0. 0x8000 - 0x0001 -> sum=0x7FFF, cout=1, overflow=1.
- Backpressure: hold out_ready=0 for 6 cycles after out_valid rises, and toggle in_valid/a/b meanwhile -> sum unchanged, in_ready=0, no new accept. Assert out_ready -> IDLE next edge, in_ready=1.
- Assert rst for 1 cycle at the 2nd RUN cycle -> next edge state IDLE, out_valid=0, sum=0, adder_* outputs=0. A subsequent 0x0001+0x0001 completes with sum=0x0002.
- Back-to-back: in_valid held high with two queued requests -> second accept occurs exactly NIBBLES+2 cycles after the first; both results correct.
